// File: rtl/lut_neuron_layer_pipe.sv
// LUT neuron layer: CHANNELS runtime-programmable truth tables, one registered lookup per input vector.
// Latency: 1 cycle from acceptance to out_valid; 1 vector/cycle when downstream keeps out_ready high.
// Backpressure: output register holds while out_valid && !out_ready; in_ready is low then and during a clear sweep.
// Optional LUT_PARITY_EN: per-entry even-parity bit with a sticky err_parity output.
module lut_neuron_layer_pipe #(
  parameter int CHANNELS = 4,
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 2,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*IN_BITS-1:0]  in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*OUT_BITS-1:0] out_data,
  input  logic                         cfg_we,
  input  logic [CH_W-1:0]              cfg_ch,
  input  logic [IN_BITS-1:0]           cfg_addr,
  input  logic [OUT_BITS-1:0]          cfg_data,
  input  logic                         cfg_clear,
  output logic                         clear_busy
`ifdef LUT_PARITY_EN
  ,
  output logic                         err_parity
`endif
);

  localparam int DEPTH = 1 << IN_BITS;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                       state;
  logic [IN_BITS-1:0]           cnt;
  logic [OUT_BITS-1:0]          tbl [CHANNELS][DEPTH];
  logic [CHANNELS*OUT_BITS-1:0] lookup;
  logic                         accept;
  logic                         sweeping;
  logic                         sweep_last;

  assign in_ready   = (state == IDLE) && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign sweeping   = (state == CLEAR);
  assign sweep_last = sweeping && (cnt == {IN_BITS{1'b1}});

  // Clear-sweep FSM: walks cnt over every table row once, clear_busy registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      clear_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_clear) begin
            state      <= CLEAR;
            cnt        <= '0;
            clear_busy <= 1'b1;
          end
        end
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == {IN_BITS{1'b1}}) begin
            state      <= IDLE;
            clear_busy <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          clear_busy <= 1'b0;
        end
      endcase
    end
  end

  // Table storage: the sweep row wins over a config write to the same entry; reads see the pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int a = 0; a < DEPTH; a++)
          tbl[c][a] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++)
        for (int a = 0; a < DEPTH; a++)
          if (sweeping && (cnt == IN_BITS'(a)))
            tbl[c][a] <= '0;
          else if (cfg_we && (cfg_ch == CH_W'(c)) && (cfg_addr == IN_BITS'(a)))
            tbl[c][a] <= cfg_data;
    end
  end

  // Combinational per-channel lookup feeding the output register.
  always_comb begin
    lookup = '0;
    for (int c = 0; c < CHANNELS; c++)
      lookup[c*OUT_BITS +: OUT_BITS] = tbl[c][in_data[c*IN_BITS +: IN_BITS]];
  end

  // Output register: load on acceptance, drop valid once the consumer takes it, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= lookup;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef LUT_PARITY_EN
  logic par     [CHANNELS][DEPTH];
  logic par_bad;

  // Parity bits track every table write, including the sweep zeroing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int a = 0; a < DEPTH; a++)
          par[c][a] <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++)
        for (int a = 0; a < DEPTH; a++)
          if (sweeping && (cnt == IN_BITS'(a)))
            par[c][a] <= 1'b0;
          else if (cfg_we && (cfg_ch == CH_W'(c)) && (cfg_addr == IN_BITS'(a)))
            par[c][a] <= ^cfg_data;
    end
  end

  // Any channel whose looked-up entry plus parity bit has odd weight flags an error.
  always_comb begin
    par_bad = 1'b0;
    for (int c = 0; c < CHANNELS; c++)
      par_bad = par_bad |
                ((^tbl[c][in_data[c*IN_BITS +: IN_BITS]]) ^ par[c][in_data[c*IN_BITS +: IN_BITS]]);
  end

  // Sticky error flag, cleared when a sweep completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_parity <= 1'b0;
    else if (sweep_last)
      err_parity <= 1'b0;
    else if (accept && par_bad)
      err_parity <= 1'b1;
  end
`else
  logic unused_sweep_last;
  assign unused_sweep_last = sweep_last;
`endif

endmodule

// File: tb/tb_lut_neuron_layer_pipe.sv
// Self-checking bench for lut_neuron_layer_pipe: table model plus directed vectors.
module tb_lut_neuron_layer_pipe;

  localparam int CHANNELS = 4;
  localparam int IN_BITS  = 6;
  localparam int OUT_BITS = 2;
  localparam int DEPTH    = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [5:0]  cfg_addr = '0;
  logic [1:0]  cfg_data = '0;
  logic        cfg_clear = 1'b0;
  logic        clear_busy;
`ifdef LUT_PARITY_EN
  logic        err_parity;
`endif

  int tests = 0;
  int fails = 0;

  lut_neuron_layer_pipe #(
    .CHANNELS(CHANNELS), .IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_clear(cfg_clear), .clear_busy(clear_busy)
`ifdef LUT_PARITY_EN
    , .err_parity(err_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] vec(input int a0, input int a1, input int a2, input int a3);
    return {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
  endfunction

  // ---------------- behavioural model ----------------
  logic [1:0] mtbl [CHANNELS][DEPTH];
  bit         have_out;
  logic [7:0] exp_out;
  int         busy_left;
  bit         exp_ready;
  bit         acc;
  logic [7:0] nxt;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int a = 0; a < DEPTH; a++)
          mtbl[c][a] = 2'b00;
      have_out  = 0;
      exp_out   = '0;
      busy_left = 0;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_clear_busy", 64'(clear_busy), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
    end else begin
      exp_ready = (busy_left == 0) && (!have_out || out_ready);
      chk("out_valid", 64'(out_valid), 64'(have_out));
      chk("clear_busy", 64'(clear_busy), 64'(busy_left > 0));
      chk("in_ready", 64'(in_ready), 64'(exp_ready));
      if (have_out)
        chk("out_data", 64'(out_data), 64'(exp_out));
      acc = in_valid && exp_ready;
      nxt = '0;
      for (int c = 0; c < CHANNELS; c++)
        nxt[c*2 +: 2] = mtbl[c][in_data[c*6 +: 6]];
      if (cfg_we)
        mtbl[cfg_ch][cfg_addr] = cfg_data;
      if (busy_left > 0)
        busy_left--;
      else if (cfg_clear) begin
        busy_left = DEPTH;
        for (int c = 0; c < CHANNELS; c++)
          for (int a = 0; a < DEPTH; a++)
            mtbl[c][a] = 2'b00;
      end
      if (acc) begin
        have_out = 1;
        exp_out  = nxt;
      end else if (out_ready) begin
        have_out = 0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int ch, input int addr, input int data);
    cfg_we   = 1'b1;
    cfg_ch   = 2'(ch);
    cfg_addr = 6'(addr);
    cfg_data = 2'(data);
    step();
    cfg_we   = 1'b0;
  endtask

  initial begin
    int n;
    step();
    step();
    rst_n = 1'b1;
    chk("ready_after_reset", 64'(in_ready), 64'd1);

    // reset then lookup: every table entry is zero
    in_data   = vec(9, 9, 9, 9);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("first_lookup_valid", 64'(out_valid), 64'd1);
    chk("first_lookup_data", 64'(out_data), 64'h00);

    // program and lookup
    cfg_write(0, 9, 3);
    cfg_write(1, 17, 1);
    in_data  = vec(9, 17, 0, 0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("prog_lookup", 64'(out_data), 64'h07);

    // backpressure: V accepted while previous drains, then W waits
    in_data  = vec(9, 17, 0, 0);
    in_valid = 1'b1;
    step();
    out_ready = 1'b0;
    in_data   = vec(0, 17, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_data", 64'(out_data), 64'h07);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("bp_release_data", 64'(out_data), 64'h04);
    step();
    chk("bp_drained", 64'(out_valid), 64'd0);

    // streaming setup
    for (int i = 0; i < 16; i++)
      cfg_write(3, i, i % 4);
    cfg_write(2, 7, 1);
    for (int i = 0; i < 16; i++) begin
      in_data  = vec(i, (i % 2) ? 17 : 0, 7, i);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    // last vector i=15: ch0 0, ch1 01, ch2 01, ch3 11
    chk("stream_last", 64'(out_data), 64'hD4);

    // read/write collision on ch2 addr 7
    in_data  = vec(0, 0, 7, 0);
    in_valid = 1'b1;
    cfg_we   = 1'b1;
    cfg_ch   = 2'd2;
    cfg_addr = 6'd7;
    cfg_data = 2'b10;
    step();
    cfg_we = 1'b0;
    chk("collision_old", 64'(out_data), 64'h10);
    step();
    in_valid = 1'b0;
    chk("collision_new", 64'(out_data), 64'h20);
    step();

    // clear sweep with input pending throughout
    cfg_clear = 1'b1;
    step();
    cfg_clear = 1'b0;
    in_data   = vec(9, 17, 7, 3);
    in_valid  = 1'b1;
    n = 0;
    while (clear_busy && n < 200) begin
      chk("sweep_in_ready", 64'(in_ready), 64'd0);
      n++;
      step();
    end
    chk("sweep_cycles", 64'(n), 64'd64);
    step();
    in_valid = 1'b0;
    chk("after_clear_valid", 64'(out_valid), 64'd1);
    chk("after_clear_data", 64'(out_data), 64'h00);
    step();

    // reset in the middle of a sweep
    cfg_write(2, 7, 3);
    cfg_clear = 1'b1;
    step();
    cfg_clear = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("mid_sweep_busy", 64'(clear_busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_sweep_busy", 64'(clear_busy), 64'd0);
    chk("reset_mid_sweep_valid", 64'(out_valid), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    in_data  = vec(0, 0, 7, 0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("post_reset_lookup", 64'(out_data), 64'h00);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
